// File: rtl/soc_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// soc_pwr_seq_ctrl
//
// Power-sequencing controller for the switchable SoC domains. Per-domain
// sleep/wake level requests are arbitrated round-robin onto one shared
// sequencer. The sequencer drives isolation, retention save/restore and the
// power-switch enable of the granted domain. All outputs are registered and
// live on the always-on supply.
//
// Ports
//   upf_clk        in   clock
//   soc_reset      in   asynchronous active-low reset
//   soc_pd_req     in   [NUM_DOM] level request: 1 = want off, 0 = want on
//   soc_psw_ack    in   [NUM_DOM] power-switch feedback: 1 = supply good
//   soc_psw_en     out  [NUM_DOM] power-switch enable: 1 = powered
//   soc_iso_en     out  [NUM_DOM] isolation enable (clamp domain outputs)
//   soc_save       out  [NUM_DOM] one-cycle retention save pulse
//   soc_restore    out  [NUM_DOM] one-cycle retention restore pulse
//   soc_dom_on     out  [NUM_DOM] committed domain state: 1 = on
//   soc_pwr_busy   out  sequencer not idle
//   soc_cur_dom    out  granted domain index (valid while busy)
//   soc_pwr_err    out  [NUM_DOM] sticky power-switch ack timeout flags
//   soc_seq_state  out  sequencer state, for debug observation
//
// Request semantics: a domain is pending while its request disagrees with
// its committed state (soc_pd_req[i] == soc_dom_on[i]). Pending is sampled
// only while idle; once granted, a sequence runs to completion regardless
// of later request changes, and soc_dom_on is the commit point. The
// requester sees completion by watching soc_dom_on follow its request.
// NUM_DOM must be at least 2.
// -----------------------------------------------------------------------------
module soc_pwr_seq_ctrl #(
    parameter int NUM_DOM     = 4,
    parameter int ISO_SETUP   = 2,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                       upf_clk,
    input  logic                       soc_reset,
    input  logic [NUM_DOM-1:0]         soc_pd_req,
    input  logic [NUM_DOM-1:0]         soc_psw_ack,
    output logic [NUM_DOM-1:0]         soc_psw_en,
    output logic [NUM_DOM-1:0]         soc_iso_en,
    output logic [NUM_DOM-1:0]         soc_save,
    output logic [NUM_DOM-1:0]         soc_restore,
    output logic [NUM_DOM-1:0]         soc_dom_on,
    output logic                       soc_pwr_busy,
    output logic [$clog2(NUM_DOM)-1:0] soc_cur_dom,
    output logic [NUM_DOM-1:0]         soc_pwr_err,
    output logic [2:0]                 soc_seq_state
);

    localparam int DOM_W   = $clog2(NUM_DOM);
    localparam int CNT_MAX = (ACK_TIMEOUT > ISO_SETUP) ? ACK_TIMEOUT : ISO_SETUP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_SETUP - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISO_ON  = 3'd1,
        S_SAVE    = 3'd2,
        S_PSW_OFF = 3'd3,
        S_PSW_ON  = 3'd4,
        S_RESTORE = 3'd5,
        S_ISO_OFF = 3'd6,
        S_DONE    = 3'd7
    } seq_state_t;

    seq_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [DOM_W-1:0]   rr_ptr;
    logic [NUM_DOM-1:0] pending;
    logic               grant_vld;
    logic [DOM_W-1:0]   grant_idx;
    logic [DOM_W-1:0]   cand;
    logic               ack_cur;

    function automatic logic [DOM_W-1:0] wrap_inc(input logic [DOM_W-1:0] v);
        return (v == DOM_W'(NUM_DOM - 1)) ? '0 : v + 1'b1;
    endfunction

    assign pending       = ~(soc_pd_req ^ soc_dom_on);
    assign ack_cur       = soc_psw_ack[soc_cur_dom];
    assign soc_seq_state = state;

    // First pending domain at or after rr_ptr, scanning with wrap-around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = rr_ptr;
        for (int k = 0; k < NUM_DOM; k++) begin
            if (!grant_vld && pending[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_ff @(posedge upf_clk or negedge soc_reset) begin
        if (!soc_reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            soc_psw_en   <= '1;
            soc_dom_on   <= '1;
            soc_iso_en   <= '0;
            soc_save     <= '0;
            soc_restore  <= '0;
            soc_pwr_err  <= '0;
            soc_pwr_busy <= 1'b0;
            soc_cur_dom  <= '0;
        end else begin
            // Save/restore are pulses: only the entering transition raises them.
            soc_save    <= '0;
            soc_restore <= '0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (grant_vld) begin
                        soc_cur_dom  <= grant_idx;
                        rr_ptr       <= wrap_inc(grant_idx);
                        soc_pwr_busy <= 1'b1;
                        // Direction is implied by the committed state: an on
                        // domain can only be pending for power-down.
                        if (soc_dom_on[grant_idx]) begin
                            state                 <= S_ISO_ON;
                            soc_iso_en[grant_idx] <= 1'b1;
                        end else begin
                            state                 <= S_PSW_ON;
                            soc_psw_en[grant_idx] <= 1'b1;
                        end
                    end
                end
                S_ISO_ON: begin
                    if (cnt == ISO_LAST) begin
                        state                 <= S_SAVE;
                        cnt                   <= '0;
                        soc_save[soc_cur_dom] <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAVE: begin
                    state                   <= S_PSW_OFF;
                    cnt                     <= '0;
                    soc_psw_en[soc_cur_dom] <= 1'b0;
                end
                S_PSW_OFF: begin
                    // A timeout is flagged but the sequence still completes.
                    if (!ack_cur || cnt == ACK_LAST) begin
                        if (ack_cur) begin
                            soc_pwr_err[soc_cur_dom] <= 1'b1;
                        end
                        soc_dom_on[soc_cur_dom] <= 1'b0;
                        state                   <= S_DONE;
                        cnt                     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PSW_ON: begin
                    if (ack_cur || cnt == ACK_LAST) begin
                        if (!ack_cur) begin
                            soc_pwr_err[soc_cur_dom] <= 1'b1;
                        end
                        soc_restore[soc_cur_dom] <= 1'b1;
                        state                    <= S_RESTORE;
                        cnt                      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESTORE: begin
                    state <= S_ISO_OFF;
                    cnt   <= '0;
                end
                S_ISO_OFF: begin
                    // Isolation is released together with the commit.
                    if (cnt == ISO_LAST) begin
                        soc_iso_en[soc_cur_dom] <= 1'b0;
                        soc_dom_on[soc_cur_dom] <= 1'b1;
                        state                   <= S_DONE;
                        cnt                     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    cnt          <= '0;
                    soc_pwr_busy <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    cnt          <= '0;
                    soc_pwr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_pwr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_soc_pwr_seq_ctrl
//
// Bench for soc_pwr_seq_ctrl. A power-switch model returns the enable one
// cycle later, optionally stuck high or low per domain. A per-cycle sampler
// records grants and busy-run lengths and checks the always-true properties.
// The reference model predicts, per request pattern, the grant order, the
// busy length of each sequence, the final committed state and the error flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_soc_pwr_seq_ctrl;

    localparam int NUM_DOM     = 4;
    localparam int ISO_SETUP   = 2;
    localparam int ACK_TIMEOUT = 16;

    logic       upf_clk = 1'b0;
    logic       soc_reset;
    logic [3:0] soc_pd_req;
    logic [3:0] soc_psw_ack = 4'hF;
    logic [3:0] soc_psw_en, soc_iso_en, soc_save, soc_restore, soc_dom_on, soc_pwr_err;
    logic       soc_pwr_busy;
    logic [1:0] soc_cur_dom;
    logic [2:0] soc_seq_state;

    int checks = 0;
    int errors = 0;

    logic [3:0] stuck_hi = 4'h0;
    logic [3:0] stuck_lo = 4'h0;

    // Sampler state
    int         sample_cyc = 0;
    int         run_len    = 0;
    logic       prev_rst   = 1'b0;
    logic       prev_busy  = 1'b0;
    logic [3:0] prev_psw, prev_iso, prev_on, prev_err;
    logic [2:0] idle_code;
    logic [1:0] grant_q[$];
    int         len_q[$];
    int         rise_q[$];
    int         fall_q[$];

    // Reference model state and scoreboard
    logic [3:0] m_dom_on;
    logic [1:0] m_rr;
    logic [3:0] m_err;
    logic [1:0] exp_q[$];
    int         exp_len_q[$];

    soc_pwr_seq_ctrl #(
        .NUM_DOM    (NUM_DOM),
        .ISO_SETUP  (ISO_SETUP),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .upf_clk      (upf_clk),
        .soc_reset    (soc_reset),
        .soc_pd_req   (soc_pd_req),
        .soc_psw_ack  (soc_psw_ack),
        .soc_psw_en   (soc_psw_en),
        .soc_iso_en   (soc_iso_en),
        .soc_save     (soc_save),
        .soc_restore  (soc_restore),
        .soc_dom_on   (soc_dom_on),
        .soc_pwr_busy (soc_pwr_busy),
        .soc_cur_dom  (soc_cur_dom),
        .soc_pwr_err  (soc_pwr_err),
        .soc_seq_state(soc_seq_state)
    );

    // ---------------- clock / reset / environment ----------------
    always #5 upf_clk = ~upf_clk;

    // Power switch: supply follows the enable one cycle later unless stuck.
    always @(posedge upf_clk) soc_psw_ack <= (soc_psw_en & ~stuck_lo) | stuck_hi;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- sampler ----------------
    task automatic tick();
        logic [3:0] other;
        @(negedge upf_clk);
        sample_cyc++;
        if (soc_reset && prev_rst) begin
            checks++;
            if ((soc_save & ~soc_psw_en) != 0 || (soc_restore & ~soc_iso_en) != 0 ||
                !$onehot0(soc_save | soc_restore)) begin
                errors++;
                $display("FAIL invariant @%0d: save=%b restore=%b psw_en=%b iso_en=%b", sample_cyc,
                         soc_save, soc_restore, soc_psw_en, soc_iso_en);
            end
            other = ~(4'b0001 << soc_cur_dom);
            checks++;
            if ((((soc_psw_en ^ prev_psw) | (soc_iso_en ^ prev_iso) | (soc_dom_on ^ prev_on) |
                  (soc_pwr_err ^ prev_err)) & other) != 0) begin
                errors++;
                $display("FAIL isolation_of_others @%0d: cur=%0d psw %b->%b iso %b->%b on %b->%b",
                         sample_cyc, soc_cur_dom, prev_psw, soc_psw_en, prev_iso, soc_iso_en,
                         prev_on, soc_dom_on);
            end
            checks++;
            if (soc_pwr_busy ? (soc_seq_state === idle_code) : (soc_seq_state !== idle_code)) begin
                errors++;
                $display("FAIL state_vs_busy @%0d: state=%0d busy=%b idle state=%0d", sample_cyc,
                         soc_seq_state, soc_pwr_busy, idle_code);
            end
        end
        if (soc_reset) begin
            if (soc_pwr_busy && !prev_busy) begin
                grant_q.push_back(soc_cur_dom);
                rise_q.push_back(sample_cyc);
                run_len = 1;
            end else if (soc_pwr_busy) begin
                run_len++;
            end
            if (!soc_pwr_busy && prev_busy) begin
                len_q.push_back(run_len);
                fall_q.push_back(sample_cyc);
            end
        end
        prev_rst  = soc_reset;
        prev_busy = soc_pwr_busy;
        prev_psw  = soc_psw_en;
        prev_iso  = soc_iso_en;
        prev_on   = soc_dom_on;
        prev_err  = soc_pwr_err;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        grant_q.delete(); len_q.delete(); rise_q.delete(); fall_q.delete();
        exp_q.delete(); exp_len_q.delete();
    endtask

    task automatic model_reset();
        m_dom_on = 4'hF;
        m_rr     = 2'd0;
        m_err    = 4'h0;
    endtask

    task automatic do_reset();
        soc_reset  = 1'b0;
        soc_pd_req = 4'h0;
        stuck_hi   = 4'h0;
        stuck_lo   = 4'h0;
        repeat (3) tick();
        soc_reset = 1'b1;
        tick();
        clear_logs();
        model_reset();
    endtask

    // Waits until the sequencer has been idle for two samples in a row.
    task automatic wait_settle(input int budget, input string tag);
        int idle_run = 0;
        int n = 0;
        while (idle_run < 2 && n < budget) begin
            tick();
            n++;
            idle_run = soc_pwr_busy ? 0 : idle_run + 1;
        end
        checks++;
        if (idle_run < 2) begin
            errors++;
            $display("FAIL %s_settle: busy=%b after %0d cycles, required idle", tag, soc_pwr_busy, n);
        end
    endtask

    // Reference model: with the request held stable, each pending domain is
    // served once in round-robin order and ends up matching its request.
    // Busy lasts ISO_SETUP + 1 (save or restore) + ack wait + 1 (done).
    // A normal switch answers one cycle after the enable changes, so the
    // wait is 2; an ack already at target gives 1; a stuck ack gives the
    // full timeout and raises the error flag.
    task automatic model_run(input logic [3:0] req);
        for (int n = 0; n < NUM_DOM; n++) begin
            logic       found;
            logic [1:0] g;
            logic [1:0] c;
            int         wait_cyc;
            found = 1'b0;
            g     = 2'd0;
            for (int k = 0; k < NUM_DOM; k++) begin
                c = m_rr + 2'(k);
                if (!found && req[c] == m_dom_on[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            if (found) begin
                exp_q.push_back(g);
                if (m_dom_on[g]) begin
                    wait_cyc = stuck_hi[g] ? ACK_TIMEOUT : (stuck_lo[g] ? 1 : 2);
                    if (stuck_hi[g]) m_err[g] = 1'b1;
                end else begin
                    wait_cyc = stuck_lo[g] ? ACK_TIMEOUT : (stuck_hi[g] ? 1 : 2);
                    if (stuck_lo[g]) m_err[g] = 1'b1;
                end
                exp_len_q.push_back(ISO_SETUP + 1 + wait_cyc + 1);
                m_dom_on[g] = ~m_dom_on[g];
                m_rr        = g + 2'd1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        soc_reset  = 1'b1;
        soc_pd_req = 4'h0;
        #3 soc_reset = 1'b0;
        #1;
        checks++;
        if ({soc_psw_en, soc_dom_on, soc_iso_en, soc_save, soc_restore, soc_pwr_err} !== 24'hFF_0000) begin
            errors++;
            $display("FAIL reset_values: psw=%b on=%b iso=%b save=%b rst=%b err=%b, required 1111 1111 0 0 0 0",
                     soc_psw_en, soc_dom_on, soc_iso_en, soc_save, soc_restore, soc_pwr_err);
        end
        checks++;
        if (soc_pwr_busy !== 1'b0 || soc_cur_dom !== 2'd0) begin
            errors++;
            $display("FAIL reset_busy: busy=%b cur=%0d, required 0 0", soc_pwr_busy, soc_cur_dom);
        end
        tick(); tick();
        idle_code  = soc_seq_state;
        soc_reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (soc_pwr_busy !== 1'b0 || soc_dom_on !== 4'hF || soc_psw_en !== 4'hF) begin
            errors++;
            $display("FAIL reset_release: busy=%b on=%b psw=%b, required 0 1111 1111", soc_pwr_busy,
                     soc_dom_on, soc_psw_en);
        end
    endtask

    task automatic test_power_down();
        do_reset();
        soc_pd_req = 4'b0010;
        tick(); // T+1
        checks++;
        if (soc_iso_en !== 4'b0010 || soc_pwr_busy !== 1'b1 || soc_cur_dom !== 2'd1) begin
            errors++;
            $display("FAIL pd_t1: iso=%b busy=%b cur=%0d, required 0010 1 1", soc_iso_en, soc_pwr_busy, soc_cur_dom);
        end
        tick(); // T+2
        checks++;
        if (soc_save !== 4'b0000) begin
            errors++;
            $display("FAIL pd_t2_save: got %b required 0000", soc_save);
        end
        tick(); // T+3
        checks++;
        if (soc_save !== 4'b0010 || soc_psw_en !== 4'hF) begin
            errors++;
            $display("FAIL pd_t3_save: save=%b psw=%b, required 0010 1111", soc_save, soc_psw_en);
        end
        tick(); // T+4
        checks++;
        if (soc_psw_en !== 4'b1101 || soc_save !== 4'b0000) begin
            errors++;
            $display("FAIL pd_t4_psw: psw=%b save=%b, required 1101 0000", soc_psw_en, soc_save);
        end
        wait_settle(100, "pd");
        checks++;
        if (soc_dom_on !== 4'b1101 || soc_psw_en !== 4'b1101 || soc_iso_en !== 4'b0010 || soc_pwr_err !== 4'h0) begin
            errors++;
            $display("FAIL pd_final: on=%b psw=%b iso=%b err=%b, required 1101 1101 0010 0000",
                     soc_dom_on, soc_psw_en, soc_iso_en, soc_pwr_err);
        end
    endtask

    task automatic test_power_up();
        logic [3:0] exp_rst[8];
        logic [3:0] exp_iso[8];
        exp_rst = '{4'h0, 4'h0, 4'h0, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0};
        exp_iso = '{4'h0, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'h0, 4'h0};
        soc_pd_req = 4'b0000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            checks++;
            if (soc_restore !== exp_rst[t] || soc_iso_en !== exp_iso[t]) begin
                errors++;
                $display("FAIL pu_t%0d: restore=%b iso=%b, required %b %b", t, soc_restore, soc_iso_en,
                         exp_rst[t], exp_iso[t]);
            end
            if (t == 1) begin
                checks++;
                if (soc_psw_en !== 4'hF || soc_dom_on !== 4'b1101) begin
                    errors++;
                    $display("FAIL pu_t1_psw: psw=%b on=%b, required 1111 1101", soc_psw_en, soc_dom_on);
                end
            end
        end
        checks++;
        if (soc_dom_on !== 4'hF || soc_pwr_busy !== 1'b0) begin
            errors++;
            $display("FAIL pu_final: on=%b busy=%b, required 1111 0", soc_dom_on, soc_pwr_busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        model_run(4'hF);
        soc_pd_req = 4'hF;
        wait_settle(200, "b2b");
        checks++;
        if (grant_q.size() != exp_q.size() || len_q.size() != exp_len_q.size()) begin
            errors++;
            $display("FAIL b2b_count: grants=%0d lens=%0d, required %0d", grant_q.size(), len_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= grant_q.size() || i >= len_q.size() || grant_q[i] !== exp_q[i] || len_q[i] != exp_len_q[i]) begin
                errors++;
                $display("FAIL b2b_grant%0d: got dom/len %0d/%0d, required %0d/%0d", i,
                         (i < grant_q.size()) ? grant_q[i] : 2'd0, (i < len_q.size()) ? len_q[i] : -1,
                         exp_q[i], exp_len_q[i]);
            end
        end
        for (int i = 1; i < rise_q.size() && i <= fall_q.size(); i++) begin
            checks++;
            if (rise_q[i] - fall_q[i-1] != 1) begin
                errors++;
                $display("FAIL b2b_gap%0d: idle %0d cycles, required 1", i, rise_q[i] - fall_q[i-1]);
            end
        end
        checks++;
        if (soc_dom_on !== 4'h0 || soc_psw_en !== 4'h0 || soc_iso_en !== 4'hF) begin
            errors++;
            $display("FAIL b2b_final: on=%b psw=%b iso=%b, required 0000 0000 1111", soc_dom_on, soc_psw_en, soc_iso_en);
        end
    endtask

    task automatic test_ack_timeout();
        int n = 0;
        do_reset();
        stuck_hi = 4'b0100;
        tick(); tick();
        model_run(4'b0100);
        soc_pd_req = 4'b0100;
        while (soc_psw_en[2] !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (soc_psw_en[2] !== 1'b0) begin
            errors++;
            $display("FAIL to_psw_low: psw=%b after %0d cycles, required bit2 low", soc_psw_en, n);
        end
        repeat (ACK_TIMEOUT - 1) tick();
        checks++;
        if (soc_pwr_err !== 4'h0 || soc_dom_on !== 4'hF) begin
            errors++;
            $display("FAIL to_early: err=%b on=%b, required 0000 1111", soc_pwr_err, soc_dom_on);
        end
        tick();
        checks++;
        if (soc_pwr_err !== 4'b0100 || soc_dom_on !== 4'b1011) begin
            errors++;
            $display("FAIL to_expire: err=%b on=%b, required 0100 1011", soc_pwr_err, soc_dom_on);
        end
        wait_settle(100, "to");
        checks++;
        if (len_q.size() != 1 || exp_len_q.size() != 1 || len_q[0] != exp_len_q[0] || soc_pwr_err !== m_err) begin
            errors++;
            $display("FAIL to_len: runs=%0d len=%0d err=%b, required 1 %0d %b", len_q.size(),
                     (len_q.size() > 0) ? len_q[0] : -1, soc_pwr_err, exp_len_q[0], m_err);
        end
        stuck_hi = 4'h0;
        tick(); tick();
        soc_pd_req = 4'h0;
        wait_settle(100, "to_up");
        checks++;
        if (soc_pwr_err !== 4'b0100 || soc_dom_on !== 4'hF) begin
            errors++;
            $display("FAIL to_sticky: err=%b on=%b, required 0100 1111", soc_pwr_err, soc_dom_on);
        end
    endtask

    task automatic test_reset_mid_save();
        int n = 0;
        do_reset();
        soc_pd_req = 4'b1000;
        while (soc_save[3] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (soc_save !== 4'b1000) begin
            errors++;
            $display("FAIL rms_save: save=%b, required 1000", soc_save);
        end
        #2 soc_reset = 1'b0;
        #1;
        checks++;
        if ({soc_psw_en, soc_dom_on, soc_iso_en, soc_save, soc_restore, soc_pwr_err} !== 24'hFF_0000 ||
            soc_pwr_busy !== 1'b0 || soc_cur_dom !== 2'd0) begin
            errors++;
            $display("FAIL rms_async: psw=%b on=%b iso=%b save=%b busy=%b cur=%0d, required reset values",
                     soc_psw_en, soc_dom_on, soc_iso_en, soc_save, soc_pwr_busy, soc_cur_dom);
        end
        tick();
        clear_logs();
        model_reset();
        model_run(4'b1000);
        soc_reset = 1'b1;
        wait_settle(100, "rms");
        checks++;
        if (grant_q.size() != 1 || grant_q[0] !== exp_q[0] || len_q.size() != 1 || len_q[0] != exp_len_q[0]) begin
            errors++;
            $display("FAIL rms_regrant: grants=%0d first=%0d, required 1 %0d", grant_q.size(),
                     (grant_q.size() > 0) ? grant_q[0] : 2'd0, exp_q[0]);
        end
        checks++;
        if (soc_dom_on !== m_dom_on) begin
            errors++;
            $display("FAIL rms_final: on=%b, required %b", soc_dom_on, m_dom_on);
        end
    endtask

    task automatic test_fairness();
        int  req_idx = -1;
        int  pos = -1;
        logic done = 1'b0;
        do_reset();
        for (int c = 0; c < 400 && !done; c++) begin
            soc_pd_req[0] = soc_dom_on[0]; // dom 0 always wants to flip
            if (c == 8) begin
                soc_pd_req[2] = 1'b1;
                req_idx = grant_q.size();
            end
            tick();
            if (req_idx >= 0 && soc_dom_on[2] == 1'b0) done = 1'b1;
        end
        for (int i = grant_q.size() - 1; i >= 0 && req_idx >= 0; i--) begin
            if (i >= req_idx && grant_q[i] == 2'd2) pos = i;
        end
        checks++;
        if (!done || pos < 0 || pos - req_idx > 1) begin
            errors++;
            $display("FAIL rr_fair: dom2 granted at position %0d after request (done=%b), required 0 or 1",
                     (pos < 0) ? -1 : pos - req_idx, done);
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        int         sel;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            sel      = $urandom_range(0, 3);
            stuck_hi = (sel == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
            stuck_lo = (sel == 1) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
            tick(); tick();
            clear_logs();
            req = 4'($urandom_range(0, 15));
            model_run(req);
            soc_pd_req = req;
            wait_settle(300, "rand");
            checks++;
            if (grant_q.size() != exp_q.size() || len_q.size() != exp_len_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: req=%b grants=%0d lens=%0d, required %0d", it, req,
                         grant_q.size(), len_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (i >= grant_q.size() || i >= len_q.size() || grant_q[i] !== exp_q[i] || len_q[i] != exp_len_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_seq%0d: got dom/len %0d/%0d, required %0d/%0d", it, i,
                             (i < grant_q.size()) ? grant_q[i] : 2'd0, (i < len_q.size()) ? len_q[i] : -1,
                             exp_q[i], exp_len_q[i]);
                end
            end
            checks++;
            if (soc_dom_on !== m_dom_on || soc_psw_en !== m_dom_on || soc_iso_en !== ~m_dom_on ||
                soc_pwr_err !== m_err) begin
                errors++;
                $display("FAIL rand%0d_state: on=%b psw=%b iso=%b err=%b, required on=%b err=%b", it,
                         soc_dom_on, soc_psw_en, soc_iso_en, soc_pwr_err, m_dom_on, m_err);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_power_down();
        test_power_up();
        test_back_to_back();
        test_ack_timeout();
        test_reset_mid_save();
        test_fairness();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
